// File: rtl/up_regmux_pkg.sv
// Shared types and constants for the up-bus register fan-out/collect stage.
package up_regmux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } regmux_state_e;

  localparam int unsigned TIMEOUT_CNT_W  = 16;
  localparam logic [31:0] ERR_RDATA_DFLT = 32'hDEADDEAD;

  // Saturating increment for the timeout event counter
  function automatic logic [TIMEOUT_CNT_W-1:0] sat_inc(input logic [TIMEOUT_CNT_W-1:0] v);
    return (&v) ? v : v + TIMEOUT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/up_regmux_ack_join.sv
// Combinational ack join: ack-masked OR of slave read data plus any/multi-hot detection.
module up_regmux_ack_join #(
  parameter int unsigned NUM_SLAVES = 4
) (
  input  logic [NUM_SLAVES-1:0]    ack,
  input  logic [NUM_SLAVES*32-1:0] rdata,
  output logic [31:0]              rdata_c,
  output logic                     any_c,
  output logic                     multi_c
);

  always_comb begin
    rdata_c = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      rdata_c = rdata_c | (rdata[32*k +: 32] & {32{ack[k]}});
    end
  end

  assign any_c   = |ack;
  // Clearing the lowest set bit leaves something only when two or more bits were set
  assign multi_c = |(ack & (ack - NUM_SLAVES'(1)));

endmodule

// File: rtl/up_tpl_regbus_mux.sv
// Up-bus fan-out/collect stage between up_axi and NUM_SLAVES register sub-blocks.
// Optional ack timeout with error completion is enabled by defining UP_REGMUX_TIMEOUT_EN.
module up_tpl_regbus_mux
  import up_regmux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DFLT
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     up_wreq,
  input  logic [ADDR_WIDTH-1:0]    up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  input  logic                     up_rreq,
  input  logic [ADDR_WIDTH-1:0]    up_raddr,
  output logic [31:0]              up_rdata,
  output logic                     up_rack,
  output logic                     s_wreq,
  output logic [ADDR_WIDTH-1:0]    s_waddr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_wack,
  output logic                     s_rreq,
  output logic [ADDR_WIDTH-1:0]    s_raddr,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_rack,
  output logic                     up_err_timeout,
  output logic                     up_err_collide,
  input  logic                     up_err_clr,
  output logic [TIMEOUT_CNT_W-1:0] up_timeout_cnt
);

  regmux_state_e           state_q;
  logic                    rd_pend_q;
  logic [NUM_SLAVES-1:0]   ack_vec_c;
  logic [31:0]             join_rdata_c;
  logic                    join_any_c;
  logic                    join_multi_c;
  logic                    timeout_c;

  // Only the ack vector belonging to the current wait state reaches the join
  always_comb begin
    ack_vec_c = '0;
    case (state_q)
      WR_WAIT: ack_vec_c = s_wack;
      RD_WAIT: ack_vec_c = s_rack;
      default: ack_vec_c = '0;
    endcase
  end

  up_regmux_ack_join #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_ack_join (
    .ack     (ack_vec_c),
    .rdata   (s_rdata),
    .rdata_c (join_rdata_c),
    .any_c   (join_any_c),
    .multi_c (join_multi_c)
  );

`ifdef UP_REGMUX_TIMEOUT_EN
  localparam int unsigned WAIT_CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [WAIT_CNT_W-1:0] wait_cnt_q;

  assign timeout_c = (state_q != IDLE) && !join_any_c &&
                     (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts in IDLE, so it is zero on every WAIT entry
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wait_cnt_q     <= '0;
      up_err_timeout <= 1'b0;
      up_timeout_cnt <= '0;
    end else begin
      wait_cnt_q     <= (state_q == IDLE) ? '0 : wait_cnt_q + WAIT_CNT_W'(1);
      up_err_timeout <= timeout_c;
      if (timeout_c) begin
        up_timeout_cnt <= up_err_clr ? TIMEOUT_CNT_W'(1) : sat_inc(up_timeout_cnt);
      end else if (up_err_clr) begin
        up_timeout_cnt <= '0;
      end
    end
  end
`else
  assign timeout_c      = 1'b0;
  assign up_err_timeout = 1'b0;
  assign up_timeout_cnt = '0;
`endif

  // Transaction FSM with registered bus outputs
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q        <= IDLE;
      rd_pend_q      <= 1'b0;
      up_wack        <= 1'b0;
      up_rack        <= 1'b0;
      up_rdata       <= '0;
      s_wreq         <= 1'b0;
      s_waddr        <= '0;
      s_wdata        <= '0;
      s_rreq         <= 1'b0;
      s_raddr        <= '0;
      up_err_collide <= 1'b0;
    end else begin
      up_wack <= 1'b0;
      up_rack <= 1'b0;
      s_wreq  <= 1'b0;
      s_rreq  <= 1'b0;

      // A collision in the same cycle as a clear keeps the flag set
      if (join_multi_c) begin
        up_err_collide <= 1'b1;
      end else if (up_err_clr) begin
        up_err_collide <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rd_pend_q) begin
            rd_pend_q <= 1'b0;
            s_rreq    <= 1'b1;
            state_q   <= RD_WAIT;
          end else if (up_wreq) begin
            s_wreq  <= 1'b1;
            s_waddr <= up_waddr;
            s_wdata <= up_wdata;
            state_q <= WR_WAIT;
            if (up_rreq) begin
              rd_pend_q <= 1'b1;
              s_raddr   <= up_raddr;
            end
          end else if (up_rreq) begin
            s_rreq  <= 1'b1;
            s_raddr <= up_raddr;
            state_q <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (join_any_c || timeout_c) begin
            up_wack <= 1'b1;
            state_q <= IDLE;
          end
        end
        RD_WAIT: begin
          if (join_any_c) begin
            up_rack  <= 1'b1;
            up_rdata <= join_rdata_c;
            state_q  <= IDLE;
          end else if (timeout_c) begin
            up_rack  <= 1'b1;
            up_rdata <= ERR_RDATA;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_tpl_regbus_mux.sv
// Directed bench for up_tpl_regbus_mux; the timeout scenario follows UP_REGMUX_TIMEOUT_EN.
module tb_up_tpl_regbus_mux;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 14;
  localparam int unsigned TO = 8;

  logic            up_clk = 1'b0;
  logic            up_rstn;
  logic            up_wreq;
  logic [AW-1:0]   up_waddr;
  logic [31:0]     up_wdata;
  logic            up_wack;
  logic            up_rreq;
  logic [AW-1:0]   up_raddr;
  logic [31:0]     up_rdata;
  logic            up_rack;
  logic            s_wreq;
  logic [AW-1:0]   s_waddr;
  logic [31:0]     s_wdata;
  logic [NS-1:0]   s_wack;
  logic            s_rreq;
  logic [AW-1:0]   s_raddr;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0]   s_rack;
  logic            up_err_timeout;
  logic            up_err_collide;
  logic            up_err_clr;
  logic [15:0]     up_timeout_cnt;

  int checks   = 0;
  int failures = 0;

  up_tpl_regbus_mux #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADDEAD)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rack(s_rack),
    .up_err_timeout(up_err_timeout), .up_err_collide(up_err_collide),
    .up_err_clr(up_err_clr), .up_timeout_cnt(up_timeout_cnt)
  );

  always #5 up_clk = ~up_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the rising edge
  task automatic tick(input int n = 1);
    repeat (n) @(posedge up_clk);
    #1;
  endtask

  task automatic set_rdata(input int k, input logic [31:0] v);
    s_rdata[32*k +: 32] = v;
  endtask

  task automatic test_reset();
    up_rstn = 1'b0; up_wreq = 1'b0; up_waddr = '0; up_wdata = '0; up_rreq = 1'b0;
    up_raddr = '0; s_wack = '0; s_rdata = '0; s_rack = '0; up_err_clr = 1'b0;
    tick(2);
    checks++;
    if ({up_wack, up_rack, s_wreq, s_rreq, up_err_timeout, up_err_collide} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {up_wack, up_rack, s_wreq, s_rreq, up_err_timeout, up_err_collide});
    end
    checks++;
    if ({up_rdata, s_waddr, s_wdata, s_raddr, up_timeout_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h waddr=%h wdata=%h raddr=%h cnt=%0d expected all 0",
               up_rdata, s_waddr, s_wdata, s_raddr, up_timeout_cnt);
    end
    up_rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_write();
    up_wreq = 1'b1; up_waddr = 14'h040; up_wdata = 32'hCAFE0040;
    tick();                                   // cycle 1
    up_wreq = 1'b0;
    checks++;
    if ({s_wreq, s_waddr, s_wdata} !== {1'b1, 14'h040, 32'hCAFE0040}) begin
      failures++;
      $display("FAIL wr_issue: s_wreq=%b s_waddr=%h s_wdata=%h expected 1 040 cafe0040",
               s_wreq, s_waddr, s_wdata);
    end
    up_rreq = 1'b1; up_raddr = 14'h3FF;       // dropped: arrives while busy
    tick();                                   // cycle 2
    up_rreq = 1'b0;
    checks++;
    if ({s_wreq, up_wack, s_waddr} !== {1'b0, 1'b0, 14'h040}) begin
      failures++;
      $display("FAIL wr_hold: s_wreq=%b up_wack=%b s_waddr=%h expected 0 0 040",
               s_wreq, up_wack, s_waddr);
    end
    s_wack = 4'b0010;
    tick();                                   // cycle 3
    s_wack = '0;
    checks++;
    if (up_wack !== 1'b1) begin
      failures++;
      $display("FAIL wr_ack_latency: up_wack=%b expected 1 three cycles after up_wreq", up_wack);
    end
    tick();
    checks++;
    if ({up_wack, s_rreq} !== 2'b00) begin
      failures++;
      $display("FAIL wr_ack_pulse_drop: up_wack=%b s_rreq=%b expected 0 0", up_wack, s_rreq);
    end
    tick();
    checks++;
    if ({s_rreq, s_raddr} !== {1'b0, 14'h000}) begin
      failures++;
      $display("FAIL dropped_rreq: s_rreq=%b s_raddr=%h expected 0 000", s_rreq, s_raddr);
    end
  endtask

  task automatic test_read();
    s_rack = 4'b0100;                          // ack in IDLE is ignored
    tick();
    s_rack = '0;
    checks++;
    if (up_rack !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack_ignored: up_rack=%b expected 0", up_rack);
    end
    up_rreq = 1'b1; up_raddr = 14'h418;
    tick();                                   // cycle 1
    up_rreq = 1'b0;
    checks++;
    if ({s_rreq, s_raddr} !== {1'b1, 14'h418}) begin
      failures++;
      $display("FAIL rd_issue: s_rreq=%b s_raddr=%h expected 1 418", s_rreq, s_raddr);
    end
    set_rdata(0, 32'hFFFF0000); set_rdata(1, 32'h0000FFFF); set_rdata(3, 32'hA5A5A5A5);
    tick();                                   // cycle 2
    set_rdata(2, 32'h12345678);
    s_rack = 4'b0100;
    tick();                                   // cycle 3
    s_rack = '0; s_rdata = '0;
    checks++;
    if ({up_rack, up_rdata, up_err_collide} !== {1'b1, 32'h12345678, 1'b0}) begin
      failures++;
      $display("FAIL rd_data: up_rack=%b up_rdata=%h collide=%b expected 1 12345678 0",
               up_rack, up_rdata, up_err_collide);
    end
    tick();
    checks++;
    if ({up_rack, up_rdata} !== {1'b0, 32'h12345678}) begin
      failures++;
      $display("FAIL rd_pulse_hold: up_rack=%b up_rdata=%h expected 0 12345678", up_rack, up_rdata);
    end
  endtask

  task automatic test_back_to_back();
    up_wreq = 1'b1; up_waddr = 14'h010; up_wdata = 32'h00000010;
    up_rreq = 1'b1; up_raddr = 14'h020;
    tick();                                   // cycle 1
    up_wreq = 1'b0; up_rreq = 1'b0;
    checks++;
    if ({s_wreq, s_rreq, s_waddr} !== {1'b1, 1'b0, 14'h010}) begin
      failures++;
      $display("FAIL b2b_write_first: s_wreq=%b s_rreq=%b s_waddr=%h expected 1 0 010",
               s_wreq, s_rreq, s_waddr);
    end
    tick();                                   // cycle 2
    s_wack = 4'b0001;
    tick();                                   // cycle 3
    s_wack = '0;
    checks++;
    if ({up_wack, up_rack, s_rreq} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_wack: up_wack=%b up_rack=%b s_rreq=%b expected 1 0 0",
               up_wack, up_rack, s_rreq);
    end
    tick();                                   // cycle 4
    checks++;
    if ({s_rreq, s_raddr, up_wack} !== {1'b1, 14'h020, 1'b0}) begin
      failures++;
      $display("FAIL b2b_read_issue: s_rreq=%b s_raddr=%h up_wack=%b expected 1 020 0",
               s_rreq, s_raddr, up_wack);
    end
    set_rdata(0, 32'hA5A50001); s_rack = 4'b0001;
    tick();                                   // cycle 5
    s_rack = '0; s_rdata = '0;
    checks++;
    if ({up_rack, up_rdata} !== {1'b1, 32'hA5A50001}) begin
      failures++;
      $display("FAIL b2b_rack: up_rack=%b up_rdata=%h expected 1 a5a50001", up_rack, up_rdata);
    end
    tick();
  endtask

  task automatic test_collision();
    up_rreq = 1'b1; up_raddr = 14'h100;
    tick();
    up_rreq = 1'b0;
    tick();
    set_rdata(0, 32'h00000F00); set_rdata(3, 32'h000000F0); s_rack = 4'b1001;
    tick();
    s_rack = '0; s_rdata = '0;
    checks++;
    if ({up_rack, up_rdata, up_err_collide} !== {1'b1, 32'h00000FF0, 1'b1}) begin
      failures++;
      $display("FAIL collide_data: up_rack=%b up_rdata=%h collide=%b expected 1 00000ff0 1",
               up_rack, up_rdata, up_err_collide);
    end
    tick(3);
    checks++;
    if (up_err_collide !== 1'b1) begin
      failures++;
      $display("FAIL collide_sticky: collide=%b expected 1", up_err_collide);
    end
    up_err_clr = 1'b1;
    tick();
    up_err_clr = 1'b0;
    checks++;
    if (up_err_collide !== 1'b0) begin
      failures++;
      $display("FAIL collide_clear: collide=%b expected 0", up_err_collide);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    set_rdata(1, 32'h11111111);               // junk without ack must not reach up_rdata
    up_rreq = 1'b1; up_raddr = 14'h200;
    tick();
    up_rreq = 1'b0;
`ifdef UP_REGMUX_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      if (up_rack !== 1'b0 || up_err_timeout !== 1'b0) early++;
      if (i < 8) tick();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL timeout_early: %0d wait cycles showed a completion, expected 0", early);
    end
    tick();                                   // cycle 9
    checks++;
    if ({up_rack, up_err_timeout, up_rdata, up_timeout_cnt} !== {1'b1, 1'b1, 32'hDEADDEAD, 16'd1}) begin
      failures++;
      $display("FAIL timeout_complete: rack=%b err=%b rdata=%h cnt=%0d expected 1 1 deaddead 1",
               up_rack, up_err_timeout, up_rdata, up_timeout_cnt);
    end
    tick();
    checks++;
    if ({up_rack, up_err_timeout, up_timeout_cnt} !== {1'b0, 1'b0, 16'd1}) begin
      failures++;
      $display("FAIL timeout_after: rack=%b err=%b cnt=%0d expected 0 0 1",
               up_rack, up_err_timeout, up_timeout_cnt);
    end
    up_err_clr = 1'b1;
    tick();
    up_err_clr = 1'b0;
    checks++;
    if (up_timeout_cnt !== 16'd0) begin
      failures++;
      $display("FAIL timeout_clear: cnt=%0d expected 0", up_timeout_cnt);
    end
    s_rdata = '0;
`else
    for (int i = 1; i <= 12; i++) begin
      if (up_rack !== 1'b0 || up_err_timeout !== 1'b0 || up_timeout_cnt !== 16'd0) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL no_timeout_hold: %0d wait cycles showed completion or error, expected 0", early);
    end
    set_rdata(2, 32'h0000BEEF); s_rack = 4'b0100;
    tick();
    s_rack = '0; s_rdata = '0;
    checks++;
    if ({up_rack, up_rdata} !== {1'b1, 32'h0000BEEF}) begin
      failures++;
      $display("FAIL no_timeout_late_ack: rack=%b rdata=%h expected 1 0000beef", up_rack, up_rdata);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    up_rreq = 1'b1; up_raddr = 14'h0AA;
    tick();
    up_rreq = 1'b0;
    tick();                                   // FSM in RD_WAIT
    up_rstn = 1'b0;
    s_rack = 4'b0001; set_rdata(0, 32'h55555555);
    #1;
    checks++;
    if ({up_rack, s_rreq, s_raddr, up_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: rack=%b s_rreq=%b s_raddr=%h rdata=%h expected all 0",
               up_rack, s_rreq, s_raddr, up_rdata);
    end
    tick(2);
    up_rstn = 1'b1;
    tick();
    s_rack = '0; s_rdata = '0;
    tick();
    checks++;
    if (up_rack !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_rack: up_rack=%b expected 0", up_rack);
    end
    up_wreq = 1'b1; up_waddr = 14'h044; up_wdata = 32'h00000044;
    tick();
    up_wreq = 1'b0;
    tick();
    s_wack = 4'b1000;
    tick();
    s_wack = '0;
    checks++;
    if ({up_wack, s_waddr} !== {1'b1, 14'h044}) begin
      failures++;
      $display("FAIL reset_mid_recover: up_wack=%b s_waddr=%h expected 1 044", up_wack, s_waddr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_collision();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
